hfir_line_ctrl: RTL and testbench
=================================

// Module: hfir_line_ctrl
// PURPOSE
//  Line sequencer for the 3-tap horizontal FIR (hfilter). Accepts a pixel stream with sof/eol,
//  replicates edge pixels (1 pre-pad, 1 post-pad per line), and drives the filter's valid_i/data_i/center_i.
//  Tags filter results, drops warm-up outputs and re-emits exactly one sof/eol-tagged result per input pixel.
//  Owns the coefficient shadow/active registers; new coefficients take effect only at frame start.
// PARAMETERS
//  DATA_WIDTH   8     pixel width
//  COEFF_WIDTH  14    signed coefficient width
//  MAX_W        2048  max pixels per line; px_cnt is $clog2(MAX_W+1) bits
//  TAG_DEPTH    4     tag FIFO depth (power of 2, >= filter latency + 2)
// PORTS
//  clk        in   1            clock
//  rst_n      in   1            asynchronous, active-low reset
//  s_valid    in   1            input pixel valid
//  s_ready    out  1            input pixel accepted when s_valid & s_ready
//  s_data     in   DATA_WIDTH   input pixel
//  s_sof      in   1            first pixel of frame
//  s_eol      in   1            last pixel of line
//  cfg_we     in   1            shadow coefficient write strobe
//  cfg_addr   in   2            0/1/2 = coeff00/01/02; 3 ignored
//  cfg_wdata  in   COEFF_WIDTH  coefficient value
//  coeff0x_o  out  COEFF_WIDTH  active coefficients to filter (x = 0,1,2; three ports)
//  f_valid    out  1            filter valid_i (one push per cycle high)
//  f_data     out  DATA_WIDTH   filter data_i
//  f_center   out  DATA_WIDTH   filter center_i (= f_data)
//  f_valid_o  in   1            filter result valid
//  f_data_o   in   DATA_WIDTH   filter result
//  m_valid    out  1            output valid (no backpressure)
//  m_data     out  DATA_WIDTH   filtered pixel
//  m_sof      out  1            m_data is first pixel of frame
//  m_eol      out  1            m_data is last pixel of line
//  busy_o     out  1            state != IDLE or tag FIFO non-empty
//  err_o      out  1            sticky error, cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE; s_ready=1; f_valid, m_valid, m_sof, m_eol, busy_o, err_o = 0;
//   f_data, f_center, m_data, hold_r, px_cnt = 0; shadow and active coefficients = 0; tag FIFO empty.
//  FSM (one push per cycle max; hold_r = last accepted pixel):
//   IDLE: s_ready=1. On accept: push s_data as pre-pad (tag drop=1), hold_r<=s_data,
//         px_cnt<=1, latch sof/eol -> DUP. On accept with s_sof: active<=shadow at same edge.
//   DUP:  s_ready=0. Push hold_r (tag drop=1). -> POST if latched eol, else RUN.
//   RUN:  s_ready=1. On accept: push s_data (tag drop=0, sof if first non-dropped tag of an sof line),
//         hold_r<=s_data, px_cnt++. -> POST on s_eol or when px_cnt reaches MAX_W (forced eol, err_o<=1).
//   POST: s_ready=0. Push hold_r (tag drop=0, eol=1). -> IDLE.
//  A line of W pixels yields W+2 pushes. The first two results are dropped; the remaining W are
//   emitted, with result k centred on pixel k-1 (edge-replicated).
//  Tags {drop,sof,eol} are written on every push and popped on every f_valid_o, so the block is
//   independent of filter latency. m_valid = f_valid_o & ~tag.drop, registered one cycle
//   (m_* valid one cycle after f_valid_o).
//  Simultaneous push and pop in one cycle is legal. f_valid_o while the tag FIFO is empty: ignore and
//   set err_o. Push while the FIFO is full: drop the tag and set err_o.
//  Single-pixel line (sof & eol on one beat): pushes pad, dup, post -> one output with m_sof=m_eol=1.
//  s_sof seen in RUN: err_o<=1; treat the beat as a normal pixel and do not reload coefficients.
//  cfg write: shadow[cfg_addr]<=cfg_wdata at any time. Active coefficients change only on sof accept
//   in IDLE. This is safe because the previous line's final push has finished its multiply stage by then.
//  Reset mid-line: everything returns to the reset state; in-flight filter results are discarded
//   because the FIFO is empty.
// STRUCTURE
//  Shared package hfir_pkg: state encoding (IDLE, DUP, RUN, POST), tag struct field positions,
//   CFG_ADDR_C00/C01/C02 constants.
//  Sub-module hfir_tag_fifo: synchronous FIFO, width 3, depth TAG_DEPTH, with full/empty flags.
//   The top level holds the FSM, counter, coefficient registers and output register.
// TESTING (bench pairs this block with hfilter; coefficients are Q2.12)
//  - Coeffs {0,4096,0}, line sof+eol of 4 pixels 10,20,30,40 -> m_data 10,20,30,40;
//    m_sof on 1st, m_eol on 4th; exactly 4 m_valid.
//  - Coeffs {1024,2048,1024}, line 0,100,200 -> m_data 25,100,175 (edge-replicated ends).
//  - Single pixel 77 with sof & eol -> one output 77 with m_sof=m_eol=1; s_ready low for 2 cycles.
//  - Write shadow mid-frame -> outputs of the current frame are unchanged; the next sof line uses the new values.
//  - MAX_W=8 and a 10-pixel line without eol -> forced eol after pixel 8, err_o=1, 8 outputs.
//  - Assert rst_n in RUN with results in flight -> no m_valid after release, busy_o=0, s_ready=1.

Source files
------------

// File: rtl/hfir_pkg.sv
// Shared definitions for the horizontal FIR line sequencer: FSM encoding,
// result tag layout and coefficient register addresses.
package hfir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUP  = 2'd1,
        RUN  = 2'd2,
        POST = 2'd3
    } state_t;

    localparam int TAG_W        = 3;
    localparam int TAG_DROP_BIT = 2;
    localparam int TAG_SOF_BIT  = 1;
    localparam int TAG_EOL_BIT  = 0;

    typedef struct packed {
        logic drop;
        logic sof;
        logic eol;
    } tag_t;

    localparam logic [1:0] CFG_ADDR_C00 = 2'd0;
    localparam logic [1:0] CFG_ADDR_C01 = 2'd1;
    localparam logic [1:0] CFG_ADDR_C02 = 2'd2;

    function automatic tag_t make_tag(input logic drop, input logic sof, input logic eol);
        tag_t t;
        t.drop = drop;
        t.sof  = sof;
        t.eol  = eol;
        return t;
    endfunction

endpackage

// File: rtl/hfir_line_ctrl_if.sv
// Input pixel stream with frame/line markers; the sink may stall via s_ready.
interface hfir_line_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_sof;
    logic                  s_eol;

    modport master (output s_valid, output s_data, output s_sof, output s_eol, input s_ready);
    modport slave  (input s_valid, input s_data, input s_sof, input s_eol, output s_ready);
endinterface

// File: rtl/hfir_tag_fifo.sv
// Small synchronous FIFO carrying per-push result tags alongside the filter pipeline.
module hfir_tag_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/hfir_line_ctrl.sv
// Line sequencer for the 3-tap horizontal FIR: edge-pads each line, tags every
// filter push, and re-emits exactly one tagged result per input pixel.
module hfir_line_ctrl
    import hfir_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 14,
    parameter int MAX_W       = 2048,
    parameter int TAG_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    hfir_line_ctrl_if.slave               s,
    input  logic                          cfg_we,
    input  logic [1:0]                    cfg_addr,
    input  logic signed [COEFF_WIDTH-1:0] cfg_wdata,
    output logic signed [COEFF_WIDTH-1:0] coeff00_o,
    output logic signed [COEFF_WIDTH-1:0] coeff01_o,
    output logic signed [COEFF_WIDTH-1:0] coeff02_o,
    output logic                          f_valid,
    output logic [DATA_WIDTH-1:0]         f_data,
    output logic [DATA_WIDTH-1:0]         f_center,
    input  logic                          f_valid_o,
    input  logic [DATA_WIDTH-1:0]         f_data_o,
    output logic                          m_valid,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_sof,
    output logic                          m_eol,
    output logic                          busy_o,
    output logic                          err_o
);
    localparam int              CNT_W   = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_W - 1);

    state_t                        state, state_nxt;
    logic [DATA_WIDTH-1:0]         hold_r;
    logic [CNT_W-1:0]              px_cnt;
    logic                          line_eol;
    logic                          sof_pend;
    logic signed [COEFF_WIDTH-1:0] shadow [3];

    logic                  accept;
    logic                  forced;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    tag_t                  push_tag;
    tag_t                  pop_tag;
    logic [TAG_W-1:0]      fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop_ok;

    always_comb begin
        state_nxt = state;
        s.s_ready = 1'b0;
        accept    = 1'b0;
        forced    = 1'b0;
        push      = 1'b0;
        push_data = hold_r;
        push_tag  = make_tag(1'b0, 1'b0, 1'b0);
        case (state)
            IDLE: begin
                s.s_ready = 1'b1;
                if (s.s_valid) begin
                    accept    = 1'b1;
                    push      = 1'b1;
                    push_data = s.s_data;
                    push_tag  = make_tag(1'b1, 1'b0, 1'b0);
                    state_nxt = DUP;
                end
            end
            DUP: begin
                push      = 1'b1;
                push_tag  = make_tag(1'b1, 1'b0, 1'b0);
                state_nxt = line_eol ? POST : RUN;
            end
            RUN: begin
                s.s_ready = 1'b1;
                if (s.s_valid) begin
                    accept    = 1'b1;
                    push      = 1'b1;
                    push_data = s.s_data;
                    push_tag  = make_tag(1'b0, sof_pend, 1'b0);
                    forced    = ~s.s_eol && (px_cnt == CNT_LAST);
                    if (s.s_eol || (px_cnt == CNT_LAST)) state_nxt = POST;
                end
            end
            POST: begin
                push      = 1'b1;
                push_tag  = make_tag(1'b0, sof_pend, 1'b1);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    hfir_tag_fifo #(.WIDTH(TAG_W), .DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_tag),
        .pop   (f_valid_o),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pop_tag  = tag_t'(fifo_rdata);
    assign pop_ok   = f_valid_o & ~fifo_empty;
    assign f_center = f_data;
    assign busy_o   = (state != IDLE) | ~fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_r    <= '0;
            px_cnt    <= '0;
            line_eol  <= 1'b0;
            sof_pend  <= 1'b0;
            f_valid   <= 1'b0;
            f_data    <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_sof     <= 1'b0;
            m_eol     <= 1'b0;
            err_o     <= 1'b0;
            coeff00_o <= '0;
            coeff01_o <= '0;
            coeff02_o <= '0;
            for (int i = 0; i < 3; i++) shadow[i] <= '0;
        end else begin
            state   <= state_nxt;
            f_valid <= push;
            if (push)   f_data <= push_data;
            if (accept) hold_r <= s.s_data;

            if ((state == IDLE) && accept) begin
                px_cnt   <= CNT_W'(1);
                line_eol <= s.s_eol | (MAX_W == 1);
                sof_pend <= s.s_sof;
                // Coefficients only switch at frame start, never mid-frame.
                if (s.s_sof) begin
                    coeff00_o <= shadow[0];
                    coeff01_o <= shadow[1];
                    coeff02_o <= shadow[2];
                end
            end
            if ((state == RUN) && accept) begin
                px_cnt   <= px_cnt + 1'b1;
                sof_pend <= 1'b0;
            end
            if (state == POST) sof_pend <= 1'b0;

            if (cfg_we) begin
                case (cfg_addr)
                    CFG_ADDR_C00: shadow[0] <= cfg_wdata;
                    CFG_ADDR_C01: shadow[1] <= cfg_wdata;
                    CFG_ADDR_C02: shadow[2] <= cfg_wdata;
                    default: ;
                endcase
            end

            if (((state == RUN) && accept && (s.s_sof || forced)) ||
                (f_valid_o && fifo_empty) ||
                (push && fifo_full && !f_valid_o))
                err_o <= 1'b1;

            m_valid <= pop_ok & ~pop_tag.drop;
            m_sof   <= pop_ok & ~pop_tag.drop & pop_tag.sof;
            m_eol   <= pop_ok & ~pop_tag.drop & pop_tag.eol;
            if (f_valid_o) m_data <= f_data_o;
        end
    end
endmodule

// File: tb/tb_hfir_line_ctrl.sv
// Directed bench: line controller paired with a two-cycle behavioural 3-tap Q2.12 filter.
module tb_hfir_line_ctrl;
    import hfir_pkg::*;

    localparam int DW   = 8;
    localparam int CW   = 14;
    localparam int MAXW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hfir_line_ctrl_if #(.DATA_WIDTH(DW)) s_if ();

    logic                 cfg_we;
    logic [1:0]           cfg_addr;
    logic signed [CW-1:0] cfg_wdata;
    logic signed [CW-1:0] coeff00_o, coeff01_o, coeff02_o;
    logic                 f_valid;
    logic [DW-1:0]        f_data, f_center;
    logic                 f_valid_o;
    logic [DW-1:0]        f_data_o;
    logic                 m_valid, m_sof, m_eol, busy_o, err_o;
    logic [DW-1:0]        m_data;

    int checks = 0;
    int errors = 0;

    hfir_line_ctrl #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .MAX_W(MAXW), .TAG_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .s(s_if),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .coeff00_o(coeff00_o), .coeff01_o(coeff01_o), .coeff02_o(coeff02_o),
        .f_valid(f_valid), .f_data(f_data), .f_center(f_center),
        .f_valid_o(f_valid_o), .f_data_o(f_data_o),
        .m_valid(m_valid), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol),
        .busy_o(busy_o), .err_o(err_o)
    );

    // Behavioural filter: result for push k = c0*p[k-2] + c1*p[k-1] + c2*p[k], rounded Q2.12.
    logic [DW-1:0] x0, x1;
    logic          v_p1;
    int            acc_p1;

    function automatic logic [DW-1:0] sat8(input int a);
        int r;
        r = (a + 2048) >>> 12;
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        return DW'(r);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0 <= '0; x1 <= '0; v_p1 <= 1'b0; acc_p1 <= 0;
            f_valid_o <= 1'b0; f_data_o <= '0;
        end else begin
            v_p1 <= f_valid;
            if (f_valid) begin
                x1 <= x0;
                x0 <= f_data;
                acc_p1 <= int'(coeff00_o) * int'(x1) + int'(coeff01_o) * int'(x0)
                        + int'(coeff02_o) * int'(f_data);
            end
            f_valid_o <= v_p1;
            f_data_o  <= sat8(acc_p1);
        end
    end

    typedef struct packed { logic [DW-1:0] d; logic sof; logic eol; } out_t;
    out_t outq[$];
    always @(negedge clk) begin
        if (m_valid) outq.push_back('{m_data, m_sof, m_eol});
    end

    logic [DW-1:0] line_buf [16];

    task automatic send_px(input logic [DW-1:0] d, input logic sof, input logic eol);
        int n;
        s_if.s_valid = 1'b1; s_if.s_data = d; s_if.s_sof = sof; s_if.s_eol = eol;
        n = 0;
        @(negedge clk);
        while (!s_if.s_ready && n < 20) begin @(negedge clk); n++; end
        if (!s_if.s_ready) begin
            checks++; errors++;
            $display("FAIL send_px_timeout: s_ready stayed %0b, required 1", s_if.s_ready);
        end
        @(posedge clk); #1;
        s_if.s_valid = 1'b0; s_if.s_sof = 1'b0; s_if.s_eol = 1'b0;
    endtask

    task automatic send_line(input int len, input logic sof, input logic eol);
        for (int i = 0; i < len; i++) send_px(line_buf[i], sof && (i == 0), eol && (i == len - 1));
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic signed [CW-1:0] v);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = v;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_coeffs(input int c0, input int c1, input int c2);
        cfg_write(CFG_ADDR_C00, CW'(c0));
        cfg_write(CFG_ADDR_C01, CW'(c1));
        cfg_write(CFG_ADDR_C02, CW'(c2));
    endtask

    task automatic drain();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_if.s_valid = 1'b0; s_if.s_data = '0; s_if.s_sof = 1'b0; s_if.s_eol = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (s_if.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b, required 1", s_if.s_ready); end
        checks++; if (f_valid !== 1'b0)      begin errors++; $display("FAIL reset_f_valid: got %b, required 0", f_valid); end
        checks++; if (f_data !== 8'd0)       begin errors++; $display("FAIL reset_f_data: got %0d, required 0", f_data); end
        checks++; if (f_center !== 8'd0)     begin errors++; $display("FAIL reset_f_center: got %0d, required 0", f_center); end
        checks++; if (m_valid !== 1'b0)      begin errors++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
        checks++; if (m_data !== 8'd0)       begin errors++; $display("FAIL reset_m_data: got %0d, required 0", m_data); end
        checks++; if (busy_o !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
        checks++; if (err_o !== 1'b0)        begin errors++; $display("FAIL reset_err: got %b, required 0", err_o); end
        checks++; if (coeff01_o !== 14'sd0)  begin errors++; $display("FAIL reset_coeff01: got %0d, required 0", coeff01_o); end
    endtask

    task automatic test_passthrough();
        int exp_d[4] = '{10, 20, 30, 40};
        set_coeffs(0, 4096, 0);
        outq.delete();
        line_buf[0] = 8'd10; line_buf[1] = 8'd20; line_buf[2] = 8'd30; line_buf[3] = 8'd40;
        send_line(4, 1'b1, 1'b1);
        drain();
        checks++; if (outq.size() !== 4) begin errors++; $display("FAIL pass_count: got %0d outputs, required 4", outq.size()); end
        for (int i = 0; i < 4 && i < outq.size(); i++) begin
            checks++; if (outq[i].d !== DW'(exp_d[i])) begin errors++; $display("FAIL pass_data[%0d]: got %0d, required %0d", i, outq[i].d, exp_d[i]); end
            checks++; if (outq[i].sof !== (i == 0)) begin errors++; $display("FAIL pass_sof[%0d]: got %b, required %b", i, outq[i].sof, i == 0); end
            checks++; if (outq[i].eol !== (i == 3)) begin errors++; $display("FAIL pass_eol[%0d]: got %b, required %b", i, outq[i].eol, i == 3); end
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL pass_busy_idle: got %b, required 0", busy_o); end
        checks++; if (err_o !== 1'b0)  begin errors++; $display("FAIL pass_err: got %b, required 0", err_o); end
    endtask

    task automatic test_smoothing();
        int exp_d[3] = '{25, 100, 175};
        set_coeffs(1024, 2048, 1024);
        outq.delete();
        line_buf[0] = 8'd0; line_buf[1] = 8'd100; line_buf[2] = 8'd200;
        send_line(3, 1'b1, 1'b1);
        drain();
        checks++; if (outq.size() !== 3) begin errors++; $display("FAIL smooth_count: got %0d outputs, required 3", outq.size()); end
        for (int i = 0; i < 3 && i < outq.size(); i++) begin
            checks++; if (outq[i].d !== DW'(exp_d[i])) begin errors++; $display("FAIL smooth_data[%0d]: got %0d, required %0d", i, outq[i].d, exp_d[i]); end
        end
    endtask

    task automatic test_single_pixel();
        set_coeffs(0, 4096, 0);
        outq.delete();
        send_px(8'd77, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (s_if.s_ready !== 1'b0) begin errors++; $display("FAIL single_ready_c1: got %b, required 0", s_if.s_ready); end
        @(negedge clk);
        checks++; if (s_if.s_ready !== 1'b0) begin errors++; $display("FAIL single_ready_c2: got %b, required 0", s_if.s_ready); end
        @(negedge clk);
        checks++; if (s_if.s_ready !== 1'b1) begin errors++; $display("FAIL single_ready_c3: got %b, required 1", s_if.s_ready); end
        drain();
        checks++; if (outq.size() !== 1) begin errors++; $display("FAIL single_count: got %0d outputs, required 1", outq.size()); end
        if (outq.size() > 0) begin
            checks++; if (outq[0].d !== 8'd77) begin errors++; $display("FAIL single_data: got %0d, required 77", outq[0].d); end
            checks++; if (outq[0].sof !== 1'b1 || outq[0].eol !== 1'b1) begin
                errors++; $display("FAIL single_tags: got sof=%b eol=%b, required 1 1", outq[0].sof, outq[0].eol);
            end
        end
    endtask

    task automatic test_shadow_coeffs();
        int exp_b[3] = '{0, 100, 200};
        int exp_c[3] = '{25, 100, 175};
        outq.delete();
        send_px(8'd8, 1'b1, 1'b0);
        set_coeffs(1024, 2048, 1024);
        send_px(8'd16, 1'b0, 1'b0);
        send_px(8'd24, 1'b0, 1'b1);
        drain();
        checks++; if (coeff01_o !== 14'sd4096) begin errors++; $display("FAIL shadow_active_held: got %0d, required 4096", coeff01_o); end
        checks++; if (outq.size() !== 3 || outq[0].d !== 8'd8 || outq[2].d !== 8'd24) begin
            errors++; $display("FAIL shadow_line_a: got %0d outputs, required 3 of 8,16,24", outq.size());
        end
        outq.delete();
        line_buf[0] = 8'd0; line_buf[1] = 8'd100; line_buf[2] = 8'd200;
        send_line(3, 1'b0, 1'b1);
        drain();
        checks++; if (outq.size() !== 3) begin errors++; $display("FAIL shadow_b_count: got %0d, required 3", outq.size()); end
        for (int i = 0; i < 3 && i < outq.size(); i++) begin
            checks++; if (outq[i].d !== DW'(exp_b[i]) || outq[i].sof !== 1'b0) begin
                errors++; $display("FAIL shadow_b[%0d]: got %0d sof=%b, required %0d sof=0", i, outq[i].d, outq[i].sof, exp_b[i]);
            end
        end
        outq.delete();
        send_line(3, 1'b1, 1'b1);
        drain();
        checks++; if (coeff01_o !== 14'sd2048) begin errors++; $display("FAIL shadow_active_new: got %0d, required 2048", coeff01_o); end
        checks++; if (outq.size() !== 3) begin errors++; $display("FAIL shadow_c_count: got %0d, required 3", outq.size()); end
        for (int i = 0; i < 3 && i < outq.size(); i++) begin
            checks++; if (outq[i].d !== DW'(exp_c[i])) begin errors++; $display("FAIL shadow_c[%0d]: got %0d, required %0d", i, outq[i].d, exp_c[i]); end
        end
    endtask

    task automatic test_max_w();
        int eol_idx;
        set_coeffs(0, 4096, 0);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL maxw_err_before: got %b, required 0", err_o); end
        outq.delete();
        for (int i = 0; i < 10; i++) line_buf[i] = DW'(11 * (i + 1));
        send_line(10, 1'b1, 1'b0);
        drain();
        eol_idx = -1;
        for (int i = 0; i < outq.size(); i++) if (eol_idx < 0 && outq[i].eol) eol_idx = i;
        checks++; if (eol_idx !== 7) begin errors++; $display("FAIL maxw_eol_pos: got output %0d, required 7", eol_idx); end
        for (int i = 0; i < 8 && i < outq.size(); i++) begin
            checks++; if (outq[i].d !== DW'(11 * (i + 1))) begin errors++; $display("FAIL maxw_data[%0d]: got %0d, required %0d", i, outq[i].d, 11 * (i + 1)); end
        end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL maxw_err: got %b, required 1", err_o); end
    endtask

    task automatic test_reset_mid_line();
        send_px(8'd1, 1'b0, 1'b0);
        send_px(8'd2, 1'b0, 1'b0);
        send_px(8'd3, 1'b0, 1'b0);
        rst_n = 1'b0;
        outq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (outq.size() !== 0)     begin errors++; $display("FAIL rst_mid_outputs: got %0d, required 0", outq.size()); end
        checks++; if (busy_o !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", busy_o); end
        checks++; if (s_if.s_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b, required 1", s_if.s_ready); end
        checks++; if (err_o !== 1'b0)        begin errors++; $display("FAIL rst_mid_err: got %b, required 0", err_o); end
        checks++; if (coeff01_o !== 14'sd0)  begin errors++; $display("FAIL rst_mid_coeff: got %0d, required 0", coeff01_o); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_passthrough();
        test_smoothing();
        test_single_pixel();
        test_shadow_coeffs();
        test_max_w();
        test_reset_mid_line();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
